// File: rtl/sensor_pkt_pkg.sv
// Shared FSM state type, frame byte indices and checksum helper for the
// sensor frame packetizer and its testbench.
package sensor_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REQ,
    WAIT_LOW,
    WAIT_HIGH,
    NEXT
  } pkt_state_t;

  localparam logic [2:0] IDX_SYNC = 3'd0;
  localparam logic [2:0] IDX_SEQ  = 3'd1;
  localparam logic [2:0] IDX_CC   = 3'd2;
  localparam logic [2:0] IDX_DC   = 3'd3;
  localparam logic [2:0] IDX_CSUM = 3'd4;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Inverted mod-256 sum of the payload bytes (seq, cc, dc).
  function automatic logic [7:0] frame_checksum(input logic [7:0] seq,
                                                input logic [7:0] cc,
                                                input logic [7:0] dc);
    logic [7:0] sum;
    sum = seq + cc + dc;
    return ~sum;
  endfunction

endpackage

// File: rtl/sensor_frame_packetizer_tick.sv
// Periodic sample tick generator (module sample_tick_gen): free-running
// timer cleared while disabled, one-cycle tick on the last count.
module sample_tick_gen #(
  parameter int PERIOD_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(PERIOD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/sensor_frame_packetizer.sv
// Snapshots the count and duty measurements on each sample tick and sends a
// framed packet (sync, seq, cc, dc) to a byte UART. Define PKT_CHECKSUM_EN to
// append an inverted-sum checksum byte.
module sensor_frame_packetizer
  import sensor_pkt_pkg::*;
#(
  parameter int         PERIOD_CYCLES = 10_000_000,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  parameter int         ACK_TIMEOUT   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] cc_value,
  input  logic [7:0] dc_value,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] seq_out,
  output logic [7:0] overrun_cnt
);

`ifdef PKT_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = IDX_CSUM;
`else
  localparam logic [2:0] LAST_IDX = IDX_DC;
`endif

  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);

  pkt_state_t    state;
  pkt_state_t    next_state;
  logic          tick;
  logic [7:0]    cc_snap;
  logic [7:0]    dc_snap;
  logic [7:0]    seq_cnt;
  logic [2:0]    idx;
  logic [AW-1:0] ack_cnt;
  logic [7:0]    byte_sel;
  logic          last_byte;

  sample_tick_gen #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  assign last_byte = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // WAIT_LOW falls through to NEXT when ready never drops, so a transmitter
  // that finishes within one cycle cannot stall the frame.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (tick) next_state = LOAD;
      LOAD:      next_state = REQ;
      REQ:       if (tx_ready) next_state = WAIT_LOW;
      WAIT_LOW: begin
        if (!tx_ready) begin
          next_state = WAIT_HIGH;
        end else if (ack_cnt == ACK_LAST) begin
          next_state = NEXT;
        end
      end
      WAIT_HIGH: if (tx_ready) next_state = NEXT;
      NEXT:      next_state = last_byte ? IDLE : LOAD;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    tx_start   = (state == REQ) && tx_ready;
    busy       = (state != IDLE);
    frame_done = (state == NEXT) && last_byte;
  end

  always_comb begin
    byte_sel = 8'h00;
    case (idx)
      IDX_SYNC: byte_sel = SYNC_BYTE;
      IDX_SEQ:  byte_sel = seq_out;
      IDX_CC:   byte_sel = cc_snap;
      IDX_DC:   byte_sel = dc_snap;
`ifdef PKT_CHECKSUM_EN
      IDX_CSUM: byte_sel = frame_checksum(seq_out, cc_snap, dc_snap);
`endif
      default:  byte_sel = 8'h00;
    endcase
  end

  // seq_cnt is the number of the next frame; seq_out latches it at snapshot
  // so the frame in flight carries the pre-increment value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cc_snap     <= 8'h00;
      dc_snap     <= 8'h00;
      seq_cnt     <= 8'h00;
      seq_out     <= 8'h00;
      overrun_cnt <= 8'h00;
      tx_data     <= 8'h00;
      idx         <= IDX_SYNC;
      ack_cnt     <= '0;
    end else begin
      if (state == IDLE && tick) begin
        cc_snap <= cc_value;
        dc_snap <= dc_value;
        seq_out <= seq_cnt;
        idx     <= IDX_SYNC;
      end
      if (tick && state != IDLE && overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
      if (state == LOAD) begin
        tx_data <= byte_sel;
      end
      if (state == WAIT_LOW) begin
        ack_cnt <= ack_cnt + AW'(1);
      end else begin
        ack_cnt <= '0;
      end
      if (state == NEXT) begin
        if (last_byte) begin
          seq_cnt <= seq_cnt + 8'd1;
          idx     <= IDX_SYNC;
        end else begin
          idx <= idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sensor_frame_packetizer.sv
// Scoreboard bench for sensor_frame_packetizer: expected frame bytes are
// queued by the stimulus and popped by a monitor on every tx_start.
module tb_sensor_frame_packetizer;

  localparam int PERIOD  = 16;
  localparam int ACK_TO  = 8;
`ifdef PKT_CHECKSUM_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif
  localparam int MODE_NORMAL = 0;
  localparam int MODE_FAST   = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] cc_value;
  logic [7:0] dc_value;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       frame_done;
  logic [7:0] seq_out;
  logic [7:0] overrun_cnt;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_seq = 8'h00;
  int         start_count = 0;
  int         frame_done_count = 0;
  int         tx_mode = MODE_NORMAL;
  int         byte_time = 20;
  int         model_timer = 0;
  logic [7:0] model_ovr = 8'h00;
  logic       pending_start = 1'b0;
  logic       prev_start = 1'b0;

  sensor_frame_packetizer #(
    .PERIOD_CYCLES(PERIOD),
    .SYNC_BYTE    (8'hA5),
    .ACK_TIMEOUT  (ACK_TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cc_value   (cc_value),
    .dc_value   (dc_value),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .busy       (busy),
    .frame_done (frame_done),
    .seq_out    (seq_out),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic flagFail(input string name, input string detail);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  // Byte-level transmitter model: ready drops one cycle after an accepted
  // start and returns byte_time cycles later; in fast mode it never drops.
  initial begin : tx_model
    int   low_cnt;
    logic start_seen;
    low_cnt    = 0;
    start_seen = 1'b0;
    tx_ready   = 1'b1;
    forever begin
      @(negedge clk);
      start_seen = tx_start && !reset;
      @(posedge clk);
      #1;
      if (reset) begin
        tx_ready = 1'b1;
        low_cnt  = 0;
      end else if (start_seen && tx_mode == MODE_NORMAL) begin
        tx_ready = 1'b0;
        low_cnt  = byte_time;
      end else if (low_cnt > 0) begin
        low_cnt--;
        if (low_cnt == 0) tx_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each tx_start and tracks an independent
  // sample-timer model to predict frame starts and dropped ticks.
  initial begin : monitor
    logic [7:0] exp_byte;
    logic       mtick;
    forever begin
      @(negedge clk);
      if (reset) begin
        model_timer   = 0;
        model_ovr     = 8'h00;
        pending_start = 1'b0;
        prev_start    = 1'b0;
      end else begin
        if (pending_start) begin
          checkOutput("frame_start_busy", int'(busy), 1);
          pending_start = 1'b0;
        end
        if (tx_start) begin
          start_count++;
          if (prev_start) flagFail("tx_start_width", "tx_start high two cycles running");
          if (exp_q.size() == 0) begin
            flagFail("unexpected_tx_start", $sformatf("got byte %02h, expected no byte", tx_data));
          end else begin
            exp_byte = exp_q.pop_front();
            checkOutput("tx_byte", int'(tx_data), int'(exp_byte));
          end
        end
        prev_start = tx_start;
        if (frame_done) frame_done_count++;
        mtick = enable && (model_timer == PERIOD - 1);
        if (mtick && busy && model_ovr != 8'hFF) model_ovr = model_ovr + 8'd1;
        if (mtick && !busy) pending_start = 1'b1;
        model_timer = (!enable || model_timer == PERIOD - 1) ? 0 : model_timer + 1;
      end
    end
  end

  task automatic waitCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic waitBusy(input logic level, input int budget, input string name);
    int n = 0;
    while (busy !== level && n < budget) begin
      waitCycle();
      n++;
    end
    if (busy !== level) flagFail(name, $sformatf("busy got %b, expected %b within %0d cycles", busy, level, budget));
  endtask

  task automatic waitFrames(input int target, input int budget, input string name);
    int n = 0;
    while (frame_done_count < target && n < budget) begin
      waitCycle();
      n++;
    end
    if (frame_done_count < target) flagFail(name, $sformatf("frames got %0d, expected %0d", frame_done_count, target));
  endtask

  task automatic waitStarts(input int target, input int budget, input string name);
    int n = 0;
    while (start_count < target && n < budget) begin
      waitCycle();
      n++;
    end
    if (start_count < target) flagFail(name, $sformatf("starts got %0d, expected %0d", start_count, target));
  endtask

  task automatic pushFrame(input logic [7:0] cc, input logic [7:0] dc);
    logic [7:0] sum;
    exp_q.push_back(8'hA5);
    exp_q.push_back(exp_seq);
    exp_q.push_back(cc);
    exp_q.push_back(dc);
`ifdef PKT_CHECKSUM_EN
    sum = exp_seq + cc + dc;
    exp_q.push_back(~sum);
`else
    sum = 8'h00;
`endif
    exp_seq = exp_seq + 8'd1 + sum[7:0] - sum[7:0];
  endtask

  // One isolated frame; cc_value is changed to late_cc once busy is seen.
  task automatic applyStimulus(input logic [7:0] cc, input logic [7:0] dc, input logic [7:0] late_cc);
    cc_value = cc;
    dc_value = dc;
    enable   = 1'b1;
    waitBusy(1'b1, 4 * PERIOD, "frame_begin");
    enable   = 1'b0;
    cc_value = late_cc;
    waitBusy(1'b0, 2000, "frame_end");
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_tx_data"},     int'(tx_data),     0);
    checkOutput({tag, "_tx_start"},    int'(tx_start),    0);
    checkOutput({tag, "_busy"},        int'(busy),        0);
    checkOutput({tag, "_frame_done"},  int'(frame_done),  0);
    checkOutput({tag, "_seq_out"},     int'(seq_out),     0);
    checkOutput({tag, "_overrun_cnt"}, int'(overrun_cnt), 0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int base;
    int s0;
    reset    = 1'b1;
    enable   = 1'b0;
    cc_value = 8'h00;
    dc_value = 8'h00;
    repeat (3) waitCycle();
    checkResetOutputs("reset");
    reset = 1'b0;
    waitCycle();

    // Frame order with a late cc change that must not reach byte 2.
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h80);
`ifdef PKT_CHECKSUM_EN
    exp_q.push_back(8'h43);
`endif
    exp_seq = 8'h01;
    applyStimulus(8'h3C, 8'h80, 8'hFF);
    checkOutput("frame_done_count_1", frame_done_count, 1);
    checkOutput("seq_out_frame1", int'(seq_out), 8'h00);

    pushFrame(8'h11, 8'h22);
    applyStimulus(8'h11, 8'h22, 8'h22);
    checkOutput("seq_out_frame2", int'(seq_out), 8'h01);

    // Fast transmitter: every byte advances via the ack timeout.
    tx_mode = MODE_FAST;
    s0 = start_count;
    pushFrame(8'h5A, 8'hC3);
    applyStimulus(8'h5A, 8'hC3, 8'hC3);
    checkOutput("fast_start_pulses", start_count - s0, FRAME_LEN);
    checkOutput("seq_out_frame3", int'(seq_out), 8'h02);
    checkOutput("frame_done_count_3", frame_done_count, 3);

    // Slow transmitter with continuous ticks: drops saturate the counter.
    tx_mode   = MODE_NORMAL;
    byte_time = 40;
    cc_value  = 8'h01;
    dc_value  = 8'h02;
    base = frame_done_count;
    for (int i = 0; i < 30; i++) pushFrame(8'h01, 8'h02);
    enable = 1'b1;
    waitFrames(base + 29, 30 * 400, "overrun_frames");
    waitBusy(1'b0, 50, "overrun_gap");
    waitBusy(1'b1, 4 * PERIOD, "overrun_last_start");
    enable = 1'b0;
    waitFrames(base + 30, 400, "overrun_last_frame");
    waitBusy(1'b0, 50, "overrun_idle");
    checkOutput("overrun_model", int'(overrun_cnt), int'(model_ovr));
    checkOutput("overrun_saturated", int'(overrun_cnt), 8'hFF);
    checkOutput("overrun_frame_count", frame_done_count - base, 30);

    // Reset while byte 2 is in flight.
    byte_time = 20;
    s0 = start_count;
    exp_q.push_back(8'hA5);
    exp_q.push_back(exp_seq);
    exp_q.push_back(8'h77);
    cc_value = 8'h77;
    dc_value = 8'h88;
    enable   = 1'b1;
    waitBusy(1'b1, 4 * PERIOD, "reset_frame_begin");
    enable = 1'b0;
    waitStarts(s0 + 3, 500, "reset_frame_byte2");
    waitCycle();
    reset = 1'b1;
    #1;
    checkResetOutputs("midreset");
    repeat (2) waitCycle();
    checkOutput("queue_empty_at_reset", exp_q.size(), 0);
    exp_q.delete();
    reset   = 1'b0;
    exp_seq = 8'h00;
    waitCycle();

    // 257 back-to-back frames: seq runs 00..FF then wraps to 00.
    tx_mode = MODE_FAST;
    cc_value = 8'h10;
    dc_value = 8'h20;
    base = frame_done_count;
    for (int i = 0; i < 257; i++) pushFrame(8'h10, 8'h20);
    enable = 1'b1;
    waitFrames(base + 256, 257 * 150, "wrap_frames");
    waitBusy(1'b0, 50, "wrap_gap");
    waitBusy(1'b1, 4 * PERIOD, "wrap_last_start");
    enable = 1'b0;
    waitFrames(base + 257, 300, "wrap_last_frame");
    waitBusy(1'b0, 50, "wrap_idle");
    checkOutput("wrap_seq_out", int'(seq_out), 8'h00);
    checkOutput("wrap_frame_count", frame_done_count - base, 257);
    checkOutput("wrap_overrun_model", int'(overrun_cnt), int'(model_ovr));
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
